mpu_mem_ctrl: RTL and testbench

MPU_MEM_CTRL -- requirements
Module: mpu_mem_ctrl

---
 rtl/mpu_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mpu_mem_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_mem_ctrl.sv
// Shared instruction/data RAM: port A serves the data bus, port B is arbitrated
// between instruction fetch and a host bridge used for program upload and readback.
module mpu_mem_ctrl #(
    parameter logic [15:0] BRIDGE_BASE = 16'h8000,
    parameter logic [15:0] DBUS_BASE   = 16'h0000,
    parameter int          WORD_AW     = 14
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ibus_cmd_valid,
    output logic        ibus_cmd_ready,
    input  logic [15:0] ibus_cmd_pc,
    output logic        ibus_rsp_valid,
    output logic [31:0] ibus_rsp_inst,
    input  logic        dbus_cmd_valid,
    input  logic        dbus_we,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    input  logic [1:0]  dbus_size,
    output logic        dbus_rsp_valid,
    output logic [31:0] dbus_rdata,
    input  logic        little_endian,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic        bridge_rd_valid,
    output logic        bridge_busy
);
    localparam int DEPTH = 1 << WORD_AW;

    typedef logic [WORD_AW-1:0] widx_t;
    typedef enum logic [1:0] {IDLE, BWR, BRD, BRSP} state_t;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [31:0] mem [DEPTH];
    logic [31:0] q_a_q, q_b_q;

    state_t      state_q, state_d;
    widx_t       baddr_q, baddr_d;
    logic [31:0] bdata_q, bdata_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_wr_q, pend_wr_d;
    widx_t       pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        ready_q, ready_d;
    logic        ibus_rsp_valid_q, ibus_rsp_valid_d;
    logic        dbus_rsp_valid_q, dbus_rsp_valid_d;
    logic        brd_valid_q, brd_valid_d;
    logic [31:0] brd_data_q, brd_data_d;

    logic        bridge_hit, hit_wr, hit_rd, hit_any, fetch_acc;
    widx_t       bridge_idx, pc_idx, dbus_idx;
    logic [3:0]  a_be;
    logic        a_we;
    logic        b_we, b_re;
    widx_t       b_waddr, b_raddr;
    logic [31:0] b_wdata;
    logic        unused_bits;

    assign bridge_hit = (bridge_addr[31:16] == BRIDGE_BASE) &&
                        ((bridge_addr[15:2] >> WORD_AW) == 14'd0);
    assign hit_wr     = bridge_hit & bridge_wr;
    assign hit_rd     = bridge_hit & bridge_rd & ~bridge_wr;
    assign hit_any    = hit_wr | hit_rd;
    assign bridge_idx = bridge_addr[WORD_AW+1:2];
    assign pc_idx     = ibus_cmd_pc[WORD_AW+1:2];
    assign dbus_idx   = dbus_addr[WORD_AW+1:2];
    assign fetch_acc  = reset_n & ibus_cmd_valid & ready_q;
    assign unused_bits = ^{ibus_cmd_pc, dbus_addr[15:0], bridge_addr[1:0]};

    always_comb begin
        a_be = 4'b1111;
        case (dbus_size)
            2'd0:    a_be = 4'b0001 << dbus_addr[1:0];
            2'd1: begin
                case (dbus_addr[1:0])
                    2'd0:    a_be = 4'b0011;
                    2'd1:    a_be = 4'b0110;
                    2'd2:    a_be = 4'b1100;
                    default: a_be = 4'b1000;
                endcase
            end
            default: a_be = 4'b1111;
        endcase
    end

    assign a_we = dbus_cmd_valid & dbus_we & (dbus_addr[31:16] == DBUS_BASE);

    // Upload path: while held in reset the bridge writes straight into port B.
    assign b_we    = reset_n ? (state_q == BWR) : hit_wr;
    assign b_waddr = reset_n ? baddr_q : bridge_idx;
    assign b_wdata = reset_n ? bdata_q : bswap(bridge_wr_data);
    assign b_re    = reset_n & ((state_q == BRD) | fetch_acc);
    assign b_raddr = (state_q == BRD) ? baddr_q : pc_idx;

    // NOTE: RAM is never reset, and reads in the same block as the writes use
    // the pre-edge contents, which gives old-data on same-address collisions.
    always_ff @(posedge clk) begin
        if (dbus_cmd_valid) q_a_q <= mem[dbus_idx];
        if (a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[dbus_idx][8*i +: 8] <= dbus_wdata[8*i +: 8];
            end
        end
        if (b_re) q_b_q <= mem[b_raddr];
        if (b_we) mem[b_waddr] <= b_wdata;
    end

    // NOTE: every _d gets a default first so this block can never infer a latch.
    always_comb begin
        state_d          = state_q;
        baddr_d          = baddr_q;
        bdata_d          = bdata_q;
        pend_valid_d     = pend_valid_q;
        pend_wr_d        = pend_wr_q;
        pend_addr_d      = pend_addr_q;
        pend_data_d      = pend_data_q;
        brd_valid_d      = 1'b0;
        brd_data_d       = brd_data_q;
        ibus_rsp_valid_d = fetch_acc;
        dbus_rsp_valid_d = dbus_cmd_valid;
        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    state_d      = pend_wr_q ? BWR : BRD;
                    baddr_d      = pend_addr_q;
                    bdata_d      = pend_data_q;
                    pend_valid_d = 1'b0;
                end else if (hit_any && !fetch_acc) begin
                    state_d = hit_wr ? BWR : BRD;
                    baddr_d = bridge_idx;
                    bdata_d = bswap(bridge_wr_data);
                end
            end
            BWR:  state_d = IDLE;
            BRD:  state_d = BRSP;
            BRSP: begin
                state_d     = IDLE;
                brd_valid_d = 1'b1;
                brd_data_d  = little_endian ? q_b_q : bswap(q_b_q);
            end
            default: state_d = IDLE;
        endcase
        // A hit that cannot start now parks in the single pending slot; a full slot drops it.
        if (hit_any && !pend_valid_q && ((state_q != IDLE) || fetch_acc)) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = hit_wr;
            pend_addr_d  = bridge_idx;
            pend_data_d  = bswap(bridge_wr_data);
        end
        ready_d = (state_d == IDLE) && !pend_valid_d;
    end

    always_ff @(posedge clk) begin
        baddr_q     <= baddr_d;
        bdata_q     <= bdata_d;
        pend_wr_q   <= pend_wr_d;
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
        if (!reset_n) begin
            state_q          <= IDLE;
            pend_valid_q     <= 1'b0;
            ready_q          <= 1'b0;
            ibus_rsp_valid_q <= 1'b0;
            dbus_rsp_valid_q <= 1'b0;
            brd_valid_q      <= 1'b0;
            brd_data_q       <= '0;
        end else begin
            state_q          <= state_d;
            pend_valid_q     <= pend_valid_d;
            ready_q          <= ready_d;
            ibus_rsp_valid_q <= ibus_rsp_valid_d;
            dbus_rsp_valid_q <= dbus_rsp_valid_d;
            brd_valid_q      <= brd_valid_d;
            brd_data_q       <= brd_data_d;
        end
    end

    assign ibus_cmd_ready  = ready_q;
    assign ibus_rsp_valid  = ibus_rsp_valid_q;
    assign ibus_rsp_inst   = q_b_q;
    assign dbus_rsp_valid  = dbus_rsp_valid_q;
    assign dbus_rdata      = q_a_q;
    assign bridge_rd_data  = brd_data_q;
    assign bridge_rd_valid = brd_valid_q;
    assign bridge_busy     = (state_q != IDLE) | pend_valid_q;

endmodule

// File: tb/tb_mpu_mem_ctrl.sv
// Self-checking bench for mpu_mem_ctrl: per-scenario tasks plus response scoreboards
// fed from a reference word model of the RAM.
module tb_mpu_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid;
    logic [15:0] ibus_cmd_pc;
    logic [31:0] ibus_rsp_inst;
    logic        dbus_cmd_valid, dbus_we, dbus_rsp_valid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [1:0]  dbus_size;
    logic        little_endian;
    logic [31:0] bridge_addr, bridge_wr_data, bridge_rd_data;
    logic        bridge_wr, bridge_rd, bridge_rd_valid, bridge_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [16384];
    logic [31:0] exp_ibus[$];
    logic [31:0] exp_dbus[$];
    logic [31:0] exp_brd[$];

    mpu_mem_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_pc(ibus_cmd_pc),
        .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_inst(ibus_rsp_inst),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_size(dbus_size),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
        .little_endian(little_endian),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
        .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
        .bridge_rd_valid(bridge_rd_valid), .bridge_busy(bridge_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [3:0]  be;
        logic [31:0] r;
        case (size)
            2'd0:    be = (lane == 2'd0) ? 4'b0001 : (lane == 2'd1) ? 4'b0010 :
                          (lane == 2'd2) ? 4'b0100 : 4'b1000;
            2'd1:    be = (lane == 2'd0) ? 4'b0011 : (lane == 2'd1) ? 4'b0110 :
                          (lane == 2'd2) ? 4'b1100 : 4'b1000;
            default: be = 4'b1111;
        endcase
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // One clock step; sample just after the edge and retire any responses.
    task automatic cyc();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (ibus_rsp_valid === 1'b1) begin
            n_checks++;
            if (exp_ibus.size() == 0) begin
                n_fail++;
                $display("FAIL ibus_rsp_unexpected: got inst %h, required no response", ibus_rsp_inst);
            end else begin
                e = exp_ibus.pop_front();
                if (ibus_rsp_inst !== e) begin
                    n_fail++;
                    $display("FAIL ibus_rsp_inst: got %h, required %h", ibus_rsp_inst, e);
                end
            end
        end
        if (dbus_rsp_valid === 1'b1) begin
            if (exp_dbus.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dbus_rsp_unexpected: got rdata %h, required no response", dbus_rdata);
            end else begin
                e = exp_dbus.pop_front();
                if (!$isunknown(e)) begin
                    n_checks++;
                    if (dbus_rdata !== e) begin
                        n_fail++;
                        $display("FAIL dbus_rdata: got %h, required %h", dbus_rdata, e);
                    end
                end
            end
        end
        if (bridge_rd_valid === 1'b1) begin
            n_checks++;
            if (exp_brd.size() == 0) begin
                n_fail++;
                $display("FAIL bridge_rd_unexpected: got data %h, required no pulse", bridge_rd_data);
            end else begin
                e = exp_brd.pop_front();
                if (bridge_rd_data !== e) begin
                    n_fail++;
                    $display("FAIL bridge_rd_data: got %h, required %h", bridge_rd_data, e);
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ibus_cmd_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (ibus_cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: ibus_cmd_ready=%b after %0d cycles, required 1", ibus_cmd_ready, n);
        end
    endtask

    task automatic fetch(input logic [15:0] pc);
        wait_ready();
        ibus_cmd_valid = 1'b1;
        ibus_cmd_pc    = pc;
        exp_ibus.push_back(model[pc[15:2]]);
        cyc();
        ibus_cmd_valid = 1'b0;
        n_checks++;
        if (ibus_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ibus_rsp_latency: rsp_valid=%b one cycle after accept, required 1", ibus_rsp_valid);
        end
        cyc();
        n_checks++;
        if (ibus_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ibus_rsp_pulse: rsp_valid=%b two cycles after accept, required 0", ibus_rsp_valid);
        end
    endtask

    task automatic dbus_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size);
        logic [13:0] idx;
        idx = addr[15:2];
        dbus_cmd_valid = 1'b1;
        dbus_we        = we;
        dbus_addr      = addr;
        dbus_wdata     = wd;
        dbus_size      = size;
        exp_dbus.push_back(model[idx]);
        if (we && addr[31:16] == 16'h0000) model[idx] = merge(model[idx], wd, size, addr[1:0]);
        cyc();
        dbus_cmd_valid = 1'b0;
        dbus_we        = 1'b0;
        n_checks++;
        if (dbus_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dbus_rsp_latency: rsp_valid=%b one cycle after cmd, required 1", dbus_rsp_valid);
        end
        cyc();
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ibus_cmd_valid = 1'b0; ibus_cmd_pc = '0;
        dbus_cmd_valid = 1'b0; dbus_we = 1'b0; dbus_addr = '0; dbus_wdata = '0; dbus_size = '0;
        little_endian = 1'b0;
        bridge_addr = '0; bridge_wr = 1'b0; bridge_wr_data = '0; bridge_rd = 1'b0;
        cyc();
        cyc();
        check_bit("reset_ready", ibus_cmd_ready, 1'b0);
        check_bit("reset_ibus_rsp_valid", ibus_rsp_valid, 1'b0);
        check_bit("reset_dbus_rsp_valid", dbus_rsp_valid, 1'b0);
        check_bit("reset_bridge_rd_valid", bridge_rd_valid, 1'b0);
        check_bit("reset_bridge_busy", bridge_busy, 1'b0);
        n_checks++;
        if (bridge_rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bridge_rd_data: got %h, required 00000000", bridge_rd_data);
        end
        // Upload during reset, with a fetch and a bridge read that must both be ignored.
        bridge_wr = 1'b1; bridge_addr = 32'h8000_0010; bridge_wr_data = 32'h1122_3344;
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 16'h0010;
        model[4] = bswap(32'h1122_3344);
        cyc();
        bridge_wr = 1'b0; bridge_rd = 1'b1;
        cyc();
        bridge_rd = 1'b0; ibus_cmd_valid = 1'b0;
        cyc();
        cyc();
        check_bit("reset_read_dropped_busy", bridge_busy, 1'b0);
        reset_n = 1'b1;
        check_bit("ready_before_release_edge", ibus_cmd_ready, 1'b0);
        cyc();
        check_bit("ready_first_edge_after_release", ibus_cmd_ready, 1'b1);
    endtask

    task automatic test_upload_fetch();
        fetch(16'h0010);
    endtask

    task automatic test_bridge_read(input logic le);
        int lat = 0;
        little_endian = le;
        wait_ready();
        bridge_rd   = 1'b1;
        bridge_addr = 32'h8000_0010;
        exp_brd.push_back(le ? model[4] : bswap(model[4]));
        while (lat < 10) begin
            cyc();
            bridge_rd = 1'b0;
            lat++;
            if (bridge_rd_valid === 1'b1) break;
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL bridge_rd_latency le=%b: got %0d cycles, required 3", le, lat);
        end
        cyc();
        check_bit("bridge_rd_valid_pulse", bridge_rd_valid, 1'b0);
    endtask

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wd; logic [1:0] size; } dop_t;

    task automatic test_dbus();
        dop_t ops[10];
        ops[0] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 2'd2};
        ops[1] = '{1'b1, 32'h0000_0003, 32'hABAB_ABAB, 2'd0};
        ops[2] = '{1'b0, 32'h0000_0000, 32'h0,         2'd2};
        ops[3] = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 2'd3};
        ops[4] = '{1'b1, 32'h0000_0006, 32'h1234_1234, 2'd1};
        ops[5] = '{1'b1, 32'h0000_0007, 32'h7777_7777, 2'd1};
        ops[6] = '{1'b1, 32'h0000_0005, 32'h9999_9999, 2'd0};
        ops[7] = '{1'b1, 32'h0000_0005, 32'h3C3C_3C3C, 2'd1};
        ops[8] = '{1'b0, 32'h0000_0004, 32'h0,         2'd2};
        ops[9] = '{1'b0, 32'h0000_0000, 32'h0,         2'd2};
        for (int i = 0; i < 10; i++) dbus_op(ops[i].we, ops[i].addr, ops[i].wd, ops[i].size);
        n_checks++;
        if (model[0] !== 32'hAB02_0304 || model[1] !== 32'h773C_3CA5) begin
            n_fail++;
            $display("FAIL dbus_model_lanes: got %h/%h, required ab020304/773c3ca5", model[0], model[1]);
        end
        // Fetch and data write to the same word in one cycle: both see old data.
        dbus_op(1'b1, 32'h0000_0080, 32'h5555_5555, 2'd2);
        wait_ready();
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 16'h0080;
        dbus_cmd_valid = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h0000_0080;
        dbus_wdata = 32'h6666_6666; dbus_size = 2'd2;
        exp_ibus.push_back(32'h5555_5555);
        exp_dbus.push_back(32'h5555_5555);
        model[32] = 32'h6666_6666;
        cyc();
        ibus_cmd_valid = 1'b0; dbus_cmd_valid = 1'b0; dbus_we = 1'b0;
        cyc();
        fetch(16'h0080);
    endtask

    task automatic test_fetch_with_bridge();
        wait_ready();
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 16'h0010;
        exp_ibus.push_back(model[4]);
        bridge_wr = 1'b1; bridge_addr = 32'h8000_0020; bridge_wr_data = 32'hCAFE_F00D;
        model[8] = bswap(32'hCAFE_F00D);
        cyc();
        ibus_cmd_valid = 1'b0; bridge_wr = 1'b0;
        check_bit("coinc_fetch_rsp", ibus_rsp_valid, 1'b1);
        check_bit("coinc_busy_0", bridge_busy, 1'b1);
        check_bit("coinc_ready_0", ibus_cmd_ready, 1'b0);
        cyc();
        check_bit("coinc_busy_1", bridge_busy, 1'b1);
        check_bit("coinc_ready_1", ibus_cmd_ready, 1'b0);
        cyc();
        check_bit("coinc_busy_2", bridge_busy, 1'b0);
        check_bit("coinc_ready_2", ibus_cmd_ready, 1'b1);
        fetch(16'h0020);
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [3];
        wd[0] = 32'hA1A2_A3A4; wd[1] = 32'hB1B2_B3B4; wd[2] = 32'hC1C2_C3C4;
        dbus_op(1'b1, 32'h0000_0048, 32'h0BAD_F00D, 2'd2);
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            bridge_wr = 1'b1; bridge_addr = 32'h8000_0040 + 32'(4 * i); bridge_wr_data = wd[i];
            cyc();
            check_bit("b2b_busy", bridge_busy, 1'b1);
        end
        bridge_wr = 1'b0;
        model[16] = bswap(wd[0]);
        model[17] = bswap(wd[1]);
        fetch(16'h0040);
        fetch(16'h0044);
        fetch(16'h0048);
        // Data write outside DBUS_BASE must leave the RAM untouched.
        dbus_op(1'b1, 32'h0001_0048, 32'hDEAD_BEEF, 2'd2);
        dbus_op(1'b0, 32'h0000_0048, 32'h0, 2'd2);
    endtask

    task automatic test_wr_rd_same_cycle();
        wait_ready();
        bridge_wr = 1'b1; bridge_rd = 1'b1;
        bridge_addr = 32'h8000_0050; bridge_wr_data = 32'h0F1E_2D3C;
        model[20] = bswap(32'h0F1E_2D3C);
        cyc();
        bridge_wr = 1'b0; bridge_rd = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        fetch(16'h0050);
    endtask

    task automatic test_reset_in_brsp();
        little_endian = 1'b0;
        wait_ready();
        bridge_rd = 1'b1; bridge_addr = 32'h8000_0010;
        cyc();
        bridge_rd = 1'b0;
        cyc();
        check_bit("brsp_busy", bridge_busy, 1'b1);
        reset_n = 1'b0;
        cyc();
        check_bit("brsp_reset_valid", bridge_rd_valid, 1'b0);
        check_bit("brsp_reset_ready", ibus_cmd_ready, 1'b0);
        check_bit("brsp_reset_busy", bridge_busy, 1'b0);
        cyc();
        reset_n = 1'b1;
        check_bit("brsp_ready_held", ibus_cmd_ready, 1'b0);
        cyc();
        check_bit("brsp_ready_after_release", ibus_cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) cyc();
        fetch(16'h0010);
    endtask

    initial begin
        test_reset();
        test_upload_fetch();
        test_bridge_read(1'b0);
        test_bridge_read(1'b1);
        test_dbus();
        test_fetch_with_bridge();
        test_back_to_back();
        test_wr_rd_same_cycle();
        test_reset_in_brsp();
        n_checks++;
        if (exp_ibus.size() != 0 || exp_dbus.size() != 0 || exp_brd.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d/%0d responses outstanding, required 0/0/0",
                     exp_ibus.size(), exp_dbus.size(), exp_brd.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
